// File: rtl/spi_loop_pkg.sv
// spi_loop_pkg: shared types for the SPI loopback self-test controller.
// Holds the burst FSM state encoding and the bit positions of the SPI
// mode word {cpol, cpha} passed between the controller and the word engine.
package spi_loop_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        GAP,
        FIN
    } state_t;

    // Mode word layout: mode[MODE_CPOL_BIT] = cpol, mode[MODE_CPHA_BIT] = cpha.
    localparam int MODE_CPHA_BIT = 0;
    localparam int MODE_CPOL_BIT = 1;

endpackage

// File: rtl/spi_word_engine.sv
// spi_word_engine: moves one DATA_W-bit word, MSB first, over SPI.
// Owns the half-period timer, SCLK generation, the MOSI shifter, the MISO
// sampler and the 2-flop MISO synchroniser. The controller loads a word on
// SETUP entry (load_i), starts the 2*DATA_W edges at the end of SETUP (go_i)
// and is told via word_done_o when the last SHIFT half-period has elapsed.
module spi_word_engine
    import spi_loop_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic [DIV_W-1:0]  half_i,
    input  logic [1:0]        mode_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] tx_word_i,
    input  logic              go_i,
    input  logic              miso_i,
    output logic              tick_o,
    output logic              word_done_o,
    output logic [DATA_W-1:0] rx_word_o,
    output logic              sclk_o,
    output logic              mosi_o
);

    localparam int EDGES = 2 * DATA_W;
    localparam int EW    = $clog2(EDGES + 1);

    logic [DIV_W-1:0]  cnt_q;
    logic [EW-1:0]     edge_q;
    logic              active_q;
    logic [DATA_W-1:0] tx_q;
    logic [DATA_W-1:0] rx_q;
    logic              sclk_q;
    logic              mosi_q;
    logic              miso_s1_q;
    logic              miso_s2_q;

    logic              last_edge;
    logic              edge_ev;
    logic              sample_ev;
    logic [EW-1:0]     edge_d;

    // Edge bookkeeping: which clock edge is an SCLK edge, and what it does.
    // NOTE: every signal gets a value on every pass through always_comb, so no latch is inferred.
    always_comb begin
        tick_o      = en_i && (cnt_q == half_i - DIV_W'(1));
        last_edge   = active_q && (edge_q == EW'(EDGES));
        word_done_o = last_edge && tick_o;
        edge_ev     = go_i || (active_q && tick_o && !last_edge);
        edge_d      = go_i ? EW'(1) : edge_q + EW'(1);
        // Odd edges are leading edges; cpha=0 samples on them, cpha=1 shifts on them.
        sample_ev   = edge_ev && (edge_d[0] != mode_i[MODE_CPHA_BIT]);
    end

    // Half-period timer: free-runs while a burst is active, wraps every H cycles.
    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (!en_i || tick_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + DIV_W'(1);
        end
    end

    // Two-flop synchroniser for the asynchronous MISO input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miso_s1_q <= 1'b0;
            miso_s2_q <= 1'b0;
        end else begin
            miso_s1_q <= miso_i;
            miso_s2_q <= miso_s1_q;
        end
    end

    // Word shifter: load on SETUP entry, then toggle SCLK and shift/sample per edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q <= 1'b0;
            edge_q   <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
        end else if (load_i) begin
            active_q <= 1'b0;
            edge_q   <= '0;
            sclk_q   <= mode_i[MODE_CPOL_BIT];
            if (!mode_i[MODE_CPHA_BIT]) begin
                // cpha=0 presents the MSB before the first edge.
                mosi_q <= tx_word_i[DATA_W-1];
                tx_q   <= tx_word_i << 1;
            end else begin
                tx_q   <= tx_word_i;
            end
        end else begin
            if (go_i) begin
                active_q <= 1'b1;
            end else if (word_done_o) begin
                active_q <= 1'b0;
            end
            if (edge_ev) begin
                edge_q <= edge_d;
                sclk_q <= ~sclk_q;
            end
            if (sample_ev) begin
                rx_q <= {rx_q[DATA_W-2:0], miso_s2_q};
            end
            if (edge_ev && !sample_ev) begin
                mosi_q <= tx_q[DATA_W-1];
                tx_q   <= tx_q << 1;
            end
        end
    end

    assign rx_word_o = rx_q;
    assign sclk_o    = sclk_q;
    assign mosi_o    = mosi_q;

endmodule

// File: rtl/spi_loop_tester.sv
// spi_loop_tester: SPI loopback self-test controller.
// Sends burst_len words (seed, seed+1, ...) over SPI in any CPOL/CPHA mode,
// compares each word returned on MISO with the word sent, and reports
// transfer/error counts and a pass flag. Optional build macro:
//   SPI_LOOP_STOP_ON_ERR_EN - end the burst after the first mismatching word.
module spi_loop_tester
    import spi_loop_pkg::*;
#(
    parameter int  DATA_W = 8,
    parameter int  NUM_CS = 2,
    parameter int  DIV_W  = 16,
    parameter int  CNT_W  = 16,
    localparam int SEL_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIV_W-1:0]  baud_div,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [SEL_W-1:0]  cs_sel,
    input  logic [CNT_W-1:0]  burst_len,
    input  logic [DATA_W-1:0] seed,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_CS-1:0] cs_n,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  xfer_count,
    output logic [CNT_W-1:0]  err_count,
    output logic [DATA_W-1:0] last_rx
);

    state_t            state_q;
    logic [DIV_W-1:0]  half_q;
    logic [1:0]        mode_q;
    logic [SEL_W-1:0]  sel_q;
    logic [CNT_W-1:0]  len_q;
    logic [DATA_W-1:0] word_q;
    logic [NUM_CS-1:0] cs_n_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;
    logic [CNT_W-1:0]  xfer_q;
    logic [CNT_W-1:0]  err_q;
    logic [DATA_W-1:0] last_rx_q;
`ifdef SPI_LOOP_STOP_ON_ERR_EN
    logic              stop_q;
`endif

    logic              tick;
    logic              word_done;
    logic [DATA_W-1:0] rx_word;
    logic              accept;
    logic              burst_over;
    logic              enter_setup;
    logic              go;
    logic              mismatch;
    logic [DATA_W-1:0] next_word;
    logic [1:0]        eng_mode;

    // Active-low select pattern; an out-of-range select asserts nothing.
    function automatic logic [NUM_CS-1:0] cs_mask(input logic [SEL_W-1:0] sel);
        logic [NUM_CS-1:0] m;
        m = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (int'(sel) == i) begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

    // Engine handshake and word bookkeeping; IDLE uses live inputs, later states the latched copy.
    always_comb begin
        accept      = (state_q == IDLE) && start;
`ifdef SPI_LOOP_STOP_ON_ERR_EN
        burst_over  = (xfer_q == len_q) || stop_q;
`else
        burst_over  = (xfer_q == len_q);
`endif
        enter_setup = (accept && (burst_len != '0)) ||
                      ((state_q == GAP) && tick && !burst_over);
        go          = (state_q == SETUP) && tick;
        next_word   = (state_q == IDLE) ? seed : word_q + DATA_W'(1);
        eng_mode    = (state_q == IDLE) ? {cpol, cpha} : mode_q;
        mismatch    = (rx_word != word_q);
    end

    spi_word_engine #(
        .DATA_W (DATA_W),
        .DIV_W  (DIV_W)
    ) u_engine (
        .clk         (clk),
        .rst         (rst),
        .en_i        (busy_q),
        .half_i      (half_q),
        .mode_i      (eng_mode),
        .load_i      (enter_setup),
        .tx_word_i   (next_word),
        .go_i        (go),
        .miso_i      (miso),
        .tick_o      (tick),
        .word_done_o (word_done),
        .rx_word_o   (rx_word),
        .sclk_o      (sclk),
        .mosi_o      (mosi)
    );

    // Burst FSM with registered status outputs and statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            half_q    <= DIV_W'(1);
            mode_q    <= '0;
            sel_q     <= '0;
            len_q     <= '0;
            word_q    <= '0;
            cs_n_q    <= '1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            xfer_q    <= '0;
            err_q     <= '0;
            last_rx_q <= '0;
`ifdef SPI_LOOP_STOP_ON_ERR_EN
            stop_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        half_q <= (baud_div == '0) ? DIV_W'(1) : baud_div;
                        mode_q <= {cpol, cpha};
                        sel_q  <= cs_sel;
                        len_q  <= burst_len;
                        word_q <= seed;
                        xfer_q <= '0;
                        err_q  <= '0;
                        pass_q <= 1'b0;
`ifdef SPI_LOOP_STOP_ON_ERR_EN
                        stop_q <= 1'b0;
`endif
                        if (burst_len == '0) begin
                            state_q <= FIN;
                            done_q  <= 1'b1;
                            pass_q  <= 1'b1;
                        end else begin
                            state_q <= SETUP;
                            busy_q  <= 1'b1;
                            cs_n_q  <= cs_mask(cs_sel);
                        end
                    end
                end
                SETUP: begin
                    if (tick) begin
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (word_done) begin
                        state_q   <= GAP;
                        cs_n_q    <= '1;
                        last_rx_q <= rx_word;
                        xfer_q    <= xfer_q + CNT_W'(1);
                        if (mismatch) begin
                            if (err_q != '1) begin
                                err_q <= err_q + CNT_W'(1);
                            end
`ifdef SPI_LOOP_STOP_ON_ERR_EN
                            stop_q <= 1'b1;
`endif
                        end
                    end
                end
                GAP: begin
                    if (tick) begin
                        if (burst_over) begin
                            state_q <= FIN;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_q == '0);
                        end else begin
                            state_q <= SETUP;
                            cs_n_q  <= cs_mask(sel_q);
                            word_q  <= next_word;
                        end
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cs_n       = cs_n_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign xfer_count = xfer_q;
    assign err_count  = err_q;
    assign last_rx    = last_rx_q;

endmodule

// File: tb/tb_spi_loop_tester.sv
// Testbench for spi_loop_tester (DATA_W=8, NUM_CS=2): table of directed bursts
// with hand-computed results, an SPI bus monitor decoding MOSI words, and
// hand-written sequences for reset state and reset mid-burst.
module tb_spi_loop_tester;

    localparam int DATA_W = 8;
    localparam int NUM_CS = 2;
    localparam int DIV_W  = 16;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [DIV_W-1:0]  baud_div = 16'd4;
    logic              cpol = 1'b0;
    logic              cpha = 1'b0;
    logic [0:0]        cs_sel = 1'b0;
    logic [CNT_W-1:0]  burst_len = 16'd0;
    logic [DATA_W-1:0] seed = 8'h00;
    logic              sclk;
    logic              mosi;
    logic              miso;
    logic [NUM_CS-1:0] cs_n;
    logic              busy;
    logic              done;
    logic              pass;
    logic [CNT_W-1:0]  xfer_count;
    logic [CNT_W-1:0]  err_count;
    logic [DATA_W-1:0] last_rx;

    logic              miso_zero = 1'b0;
    assign miso = miso_zero ? 1'b0 : mosi;

    spi_loop_tester #(
        .DATA_W (DATA_W),
        .NUM_CS (NUM_CS),
        .DIV_W  (DIV_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .baud_div   (baud_div),
        .cpol       (cpol),
        .cpha       (cpha),
        .cs_sel     (cs_sel),
        .burst_len  (burst_len),
        .seed       (seed),
        .sclk       (sclk),
        .mosi       (mosi),
        .miso       (miso),
        .cs_n       (cs_n),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .xfer_count (xfer_count),
        .err_count  (err_count),
        .last_rx    (last_rx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // SPI bus monitor: decodes MOSI on the sampling edge of the current mode.
    logic       mon_clr = 1'b0;
    logic       mon_cpol = 1'b0;
    logic       mon_cpha = 1'b0;
    logic [7:0] mon_words [0:15];
    int         mon_n = 0;
    int         mon_bits = 0;
    logic [7:0] mon_sh = 8'h00;
    int         mon_falls [0:1];
    logic       prev_sclk = 1'b0;
    logic [1:0] prev_cs = 2'b11;

    always @(negedge clk) begin
        if (mon_clr) begin
            mon_n        = 0;
            mon_bits     = 0;
            mon_sh       = 8'h00;
            mon_falls[0] = 0;
            mon_falls[1] = 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (prev_cs[i] && !cs_n[i]) mon_falls[i]++;
            end
            if (prev_cs != 2'b11 && cs_n != 2'b11 && sclk != prev_sclk) begin
                if ((sclk != mon_cpol) != mon_cpha) begin
                    mon_sh = {mon_sh[6:0], mosi};
                    mon_bits++;
                    if (mon_bits == 8) begin
                        if (mon_n < 16) mon_words[mon_n] = mon_sh;
                        mon_n++;
                        mon_bits = 0;
                    end
                end
            end
        end
        prev_sclk = sclk;
        prev_cs   = cs_n;
    end

    typedef struct {
        logic        cpol;
        logic        cpha;
        logic [15:0] baud;
        logic [7:0]  seed;
        logic [15:0] len;
        logic        sel;
        logic        miso_zero;
        logic        mid_start;
        logic        exp_pass;
        logic [15:0] exp_err;
        logic [15:0] exp_xfer;
        logic [7:0]  exp_rx;
        int          exp_cyc;
    } vec_t;

    function automatic vec_t mk(input logic p, input logic h, input logic [15:0] b,
                                input logic [7:0] s, input logic [15:0] l, input logic cs,
                                input logic mz, input logic ms, input logic ep,
                                input logic [15:0] ee, input logic [15:0] ex,
                                input logic [7:0] er, input int ec);
        vec_t v;
        v.cpol = p; v.cpha = h; v.baud = b; v.seed = s; v.len = l; v.sel = cs;
        v.miso_zero = mz; v.mid_start = ms; v.exp_pass = ep; v.exp_err = ee;
        v.exp_xfer = ex; v.exp_rx = er; v.exp_cyc = ec;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int cyc;
        logic [7:0] ew;
        @(negedge clk);
        mon_clr   = 1'b1;
        miso_zero = v.miso_zero;
        mon_cpol  = v.cpol;
        mon_cpha  = v.cpha;
        @(negedge clk);
        @(negedge clk);
        mon_clr   = 1'b0;
        cpol      = v.cpol;
        cpha      = v.cpha;
        baud_div  = v.baud;
        seed      = v.seed;
        burst_len = v.len;
        cs_sel    = v.sel;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        check({tag, ".busy_start"}, 32'(busy), 32'(v.len != 16'd0));
        while (!done && cyc < v.exp_cyc + 40) begin
            @(negedge clk);
            cyc++;
            if (v.mid_start && cyc == 50) begin
                start     = 1'b1;
                seed      = 8'h00;
                burst_len = 16'd9;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check({tag, ".done_cycle"}, 32'(cyc), 32'(v.exp_cyc));
        check({tag, ".done"}, 32'(done), 32'd1);
        check({tag, ".busy_end"}, 32'(busy), 32'd0);
        check({tag, ".pass"}, 32'(pass), 32'(v.exp_pass));
        check({tag, ".err_count"}, 32'(err_count), 32'(v.exp_err));
        check({tag, ".xfer_count"}, 32'(xfer_count), 32'(v.exp_xfer));
        check({tag, ".last_rx"}, 32'(last_rx), 32'(v.exp_rx));
        check({tag, ".cs_n_idle"}, 32'(cs_n), 32'h3);
        if (v.len != 16'd0) check({tag, ".sclk_idle"}, 32'(sclk), 32'(v.cpol));
        check({tag, ".mon_words"}, 32'(mon_n), 32'(v.exp_xfer));
        check({tag, ".cs_sel_falls"}, 32'(mon_falls[v.sel]), 32'(v.exp_xfer));
        check({tag, ".cs_other_falls"}, 32'(mon_falls[!v.sel]), 32'd0);
        for (int i = 0; i < int'(v.exp_xfer) && i < 16 && i < mon_n; i++) begin
            ew = v.seed + 8'(i);
            check($sformatf("%s.mosi_word%0d", tag, i), 32'(mon_words[i]), 32'(ew));
        end
        @(negedge clk);
        check({tag, ".done_pulse"}, 32'(done), 32'd0);
        check({tag, ".pass_hold"}, 32'(pass), 32'(v.exp_pass));
    endtask

    vec_t vecs [0:7];

    initial begin
        int cyc;
        // cpol cpha baud seed len sel mz ms | pass err xfer rx cycles
        vecs[0] = mk(0, 0, 16'd4, 8'h5A, 16'd4, 0, 0, 0, 1, 16'd0, 16'd4, 8'h5D, 289);
        vecs[1] = mk(0, 1, 16'd3, 8'h10, 16'd2, 0, 0, 0, 1, 16'd0, 16'd2, 8'h11, 109);
        vecs[2] = mk(1, 0, 16'd3, 8'hFF, 16'd2, 0, 0, 0, 1, 16'd0, 16'd2, 8'h00, 109);
        vecs[3] = mk(1, 1, 16'd5, 8'h80, 16'd2, 0, 0, 0, 1, 16'd0, 16'd2, 8'h81, 181);
`ifdef SPI_LOOP_STOP_ON_ERR_EN
        vecs[4] = mk(0, 0, 16'd4, 8'h00, 16'd3, 0, 1, 0, 0, 16'd1, 16'd2, 8'h00, 145);
`else
        vecs[4] = mk(0, 0, 16'd4, 8'h00, 16'd3, 0, 1, 0, 0, 16'd2, 16'd3, 8'h00, 217);
`endif
        vecs[5] = mk(0, 0, 16'd3, 8'h33, 16'd3, 1, 0, 1, 1, 16'd0, 16'd3, 8'h35, 163);
        vecs[6] = mk(0, 0, 16'd4, 8'h77, 16'd0, 0, 0, 0, 1, 16'd0, 16'd0, 8'h35, 1);
        vecs[7] = mk(0, 0, 16'd0, 8'h00, 16'd1, 0, 1, 0, 1, 16'd0, 16'd1, 8'h00, 19);

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst.sclk", 32'(sclk), 32'd0);
        check("rst.mosi", 32'(mosi), 32'd0);
        check("rst.cs_n", 32'(cs_n), 32'h3);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.pass", 32'(pass), 32'd0);
        check("rst.xfer", 32'(xfer_count), 32'd0);
        check("rst.err", 32'(err_count), 32'd0);
        check("rst.last_rx", 32'(last_rx), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end

        // Reset in the middle of word 2 of a 4-word burst.
        @(negedge clk);
        miso_zero = 1'b0;
        cpol = 1'b0; cpha = 1'b0; baud_div = 16'd4; seed = 8'h40;
        burst_len = 16'd4; cs_sel = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc < 180) begin
            @(negedge clk);
            cyc++;
        end
        check("midrst.cs_active", 32'(cs_n[0]), 32'd0);
        check("midrst.xfer_before", 32'(xfer_count), 32'd2);
        rst = 1'b1;
        #1;
        check("midrst.cs_n", 32'(cs_n), 32'h3);
        check("midrst.busy", 32'(busy), 32'd0);
        check("midrst.xfer", 32'(xfer_count), 32'd0);
        check("midrst.err", 32'(err_count), 32'd0);
        check("midrst.last_rx", 32'(last_rx), 32'd0);
        check("midrst.sclk", 32'(sclk), 32'd0);
        repeat (2) @(negedge clk);
        check("midrst.no_done", 32'(done), 32'd0);
        rst = 1'b0;
        run_vec(vecs[0], "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_loop_tester.md
# spi_loop_tester

Parametrised SPI loopback self-test controller, successor to the fixed 8-bit, mode-0, single-shot master/slave loopback check. It drives an SPI bus with a burst of deterministic words and compares what returns on MISO (looped externally or through a slave) against what it sent. It supports any word width, all four CPOL/CPHA modes, multiple chip selects, and reports error and transfer counts. It sits at the top level of bring-up and board-test builds, behind the PLL clock.

## Interface
Parameters:
- DATA_W, 8: bits per word, ≥2, MSB first.
- NUM_CS, 2: number of chip-select lines, ≥1.
- DIV_W, 16: width of baud_div.
- CNT_W, 16: width of burst_len, xfer_count and err_count.

Ports:
- clk  in  1  system (PLL) clock.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  launch a burst; honoured only when busy=0.
- baud_div  in  DIV_W  SCLK half-period in clk cycles; 0 is treated as 1.
- cpol  in  1  SCLK idle level.
- cpha  in  1  0: sample on leading edge; 1: sample on trailing edge.
- cs_sel  in  max(1,$clog2(NUM_CS))  selects which cs_n line to assert.
- burst_len  in  CNT_W  number of words in the burst.
- seed  in  DATA_W  value of word 0.
- sclk  out  1  SPI clock.
- mosi  out  1  SPI data out.
- miso  in  1  SPI data in; synchronised with 2 flops.
- cs_n  out  NUM_CS  active-low chip selects.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse at burst end.
- pass  out  1  last burst had zero mismatches; held until the next accepted start.
- xfer_count  out  CNT_W  words completed in the current or last burst.
- err_count  out  CNT_W  mismatching words; saturates at all-ones.
- last_rx  out  DATA_W  most recent received word.

## Operation
- Word i transmitted = (seed + i) mod 2^DATA_W. The expected receive value equals the transmitted word (loopback).
- At an accepted start, latch baud_div, cpol, cpha, cs_sel, burst_len and seed. Clear xfer_count, err_count and pass.
- FSM states and transitions:
  - IDLE: on start, go to SETUP. If burst_len=0, go directly to FIN.
  - SETUP: cs_n[cs_sel]=0, sclk=cpol. If cpha=0, mosi = word MSB. Lasts 1 half-period, then go to SHIFT.
  - SHIFT: 2·DATA_W half-periods, sclk toggles on each.
    - cpha=0: sample on odd edges, shift on even edges.
    - cpha=1: shift on odd edges, sample on even edges.
    - After the last edge, compare the word, update last_rx, increment xfer_count, and increment err_count on mismatch. Then go to GAP.
  - GAP: cs_n all 1, sclk=cpol, for 1 half-period. Then go to SETUP if words remain, else to FIN.
  - FIN: done=1 and pass=(err_count==0) for one cycle, then go to IDLE.
- start while busy=1 is ignored. Input changes while busy have no effect.
- cs_sel ≥ NUM_CS: no cs_n asserted, but the burst still runs.
- Reset asserted mid-burst: outputs return immediately to their reset values; the burst is abandoned and done is not pulsed.

## Timing
- Reset values:
  - sclk=0, mosi=0, cs_n all 1.
  - busy=0, done=0, pass=0.
  - xfer_count=0, err_count=0, last_rx=0.
- With H = max(baud_div,1), start sampled high at edge T gives:
  - busy=1 from T+1.
  - done high in cycle T+1+burst_len·(2·DATA_W+2)·H, and busy falls in the same cycle.
  - burst_len=0 gives done at T+1 with pass=1.
- All outputs are registered. The sample point includes the 2-cycle MISO synchroniser delay, so H≥3 is required for loopback correctness. With H<3 the block still runs, but a mismatch is reported.
- A new start is accepted in the cycle after done.

## Configuration
- SPI_LOOP_STOP_ON_ERR_EN:
  - Defined: on the first mismatching word, the burst ends via GAP→FIN. xfer_count includes the failing word and err_count=1.
  - Undefined: every burst runs all burst_len words.

## Structure
- Package spi_loop_pkg holds the FSM state enum (IDLE, SETUP, SHIFT, GAP, FIN) and the mode bit constants.
- Sub-module spi_word_engine:
  - Handles the half-period tick counter, SCLK generation, shift/sample for one DATA_W word, and the MISO synchroniser.
  - Handshake: go in; word_done and rx_word out.
- The top level owns the FSM, the pattern counter, the comparison and the statistics.

## Test plan
- Mode 0, DATA_W=8, baud_div=4, seed=0x5A, burst_len=4, mosi looped to miso → words 5A,5B,5C,5D; done at T+1+4·18·4=T+289; pass=1, err_count=0, xfer_count=4.
- All four cpol/cpha combinations, burst_len=2 → sclk idles at cpol and pass=1 in each mode; an SPI monitor decodes identical words.
- miso tied 0, seed=0x00, burst_len=3 → word 00 matches, 01 and 02 fail; err_count=2, pass=0. With SPI_LOOP_STOP_ON_ERR_EN: xfer_count=2, err_count=1.
- cs_sel=1, NUM_CS=2 → only cs_n[1] toggles, deasserted between words; start pulsed mid-burst is ignored.
- burst_len=0 → done at T+1, pass=1, cs_n stays all 1.
- rst asserted midway through word 2 → cs_n all 1, busy=0, counts 0 in the same cycle; a subsequent start runs cleanly.
